// File: rtl/fsm_lat_test_pkg.sv
// Shared types and constants for the start/stop latency meter.
package fsm_lat_test_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_SAT = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    OVF  = 2'd3
  } state_t;

  // Last prescaler phase before a tick: 2^sel - 1.
  function automatic logic [2:0] pre_last(input logic [1:0] sel);
    case (sel)
      2'd0:    pre_last = 3'd0;
      2'd1:    pre_last = 3'd1;
      2'd2:    pre_last = 3'd3;
      default: pre_last = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/lat_prescaler.sv
// Prescaler phase counter; tick fires once every 2^sel enabled cycles.
module lat_prescaler
  import fsm_lat_test_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] sel,
  output logic [2:0] pre,
  output logic       tick
);

  assign tick = en & (pre == pre_last(sel));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      pre <= '0;
    end else if (clr || tick) begin
      pre <= '0;
    end else if (en) begin
      pre <= pre + 3'd1;
    end
  end

endmodule

// File: rtl/fsm_lat_test.sv
// Start-to-stop latency meter: counts prescaled cycles between rising edges
// of the start and stop pins, saturating at 255.
//
// state | meaning
// IDLE  | waiting for first start edge, out shows 0
// RUN   | counting prescaler ticks, out shows live count
// DONE  | stop seen, result held
// OVF   | count saturated before stop, result held at 255
module fsm_lat_test
  import fsm_lat_test_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset,
  input  logic [4:0] in,
  output logic [7:0] out
);

  logic [4:0]       in_q, in_qq, rise;
  state_t           state;
  logic [CNT_W-1:0] cnt, result;
  logic [1:0]       sel;
  logic [2:0]       pre;
  logic             tick, run, stop_ev, arm;
  logic             unused_rise;

  assign rise        = in_q & ~in_qq;
  assign unused_rise = ^{rise[4], rise[2:1], pre};
  assign run         = (state == RUN);
  // In RUN a coincident stop beats start; elsewhere stop is ignored.
  assign stop_ev     = run & rise[3];
  assign arm         = rise[0] & ~stop_ev;

  lat_prescaler u_pre (
    .clk_in (clk_in),
    .reset  (reset),
    .clr    (arm),
    .en     (run),
    .sel    (sel),
    .pre    (pre),
    .tick   (tick)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      in_q   <= '0;
      in_qq  <= '0;
      state  <= IDLE;
      cnt    <= '0;
      sel    <= '0;
      result <= '0;
    end else begin
      in_q  <= in;
      in_qq <= in_q;
      unique case (state)
        RUN: begin
          if (rise[3]) begin
            state  <= DONE;
            result <= (tick && cnt == CNT_SAT) ? CNT_SAT
                                               : cnt + {{(CNT_W-1){1'b0}}, tick};
          end else if (rise[0]) begin
            cnt <= '0;
            sel <= in_q[2:1];
          end else if (tick) begin
            if (cnt == CNT_SAT) begin
              state  <= OVF;
              result <= CNT_SAT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          if (rise[0]) begin
            state <= RUN;
            cnt   <= '0;
            sel   <= in_q[2:1];
          end
        end
      endcase
    end
  end

  always_comb begin
    out = '0;
    if (in_q[4]) begin
      out = {state, sel, 3'b000, run};
    end else begin
      case (state)
        IDLE:    out = '0;
        RUN:     out = cnt;
        default: out = result;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_lat_test.sv
// Scoreboard bench for fsm_lat_test: stimulus queues expected out values per cycle,
// a negedge monitor pops and compares them.
module tb_fsm_lat_test;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic [4:0] in     = 5'd0;
  logic [7:0] out;

  fsm_lat_test dut (
    .clk_in (clk_in),
    .reset  (reset),
    .in     (in),
    .out    (out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mx;
  int   compared   = 0;
  int   mismatched = 0;

  task automatic push(input int at, input logic [7:0] e, input string n);
    exp_t x;
    x.at = at; x.exp = e; x.name = n;
    sb.push_back(x);
  endtask

  always @(negedge clk_in) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mx = sb.pop_front();
      compared++;
      if (mx.at != cyc || out !== mx.exp) begin
        mismatched++;
        $display("FAIL %s cycle=%0d due=%0d out=0x%02h required=0x%02h",
                 mx.name, cyc, mx.at, out, mx.exp);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] status(input int st, input int sl);
    logic [1:0] s2, l2;
    s2 = st[1:0];
    l2 = sl[1:0];
    return {s2, l2, 3'b000, (st == 1)};
  endfunction

  // Reference: spacing n at prescale 2^sel gives n>>sel ticks; overflow happens
  // if 256 ticks accumulate on the cycles strictly before the stop takes effect.
  task automatic measure(input int sl, input int n, input string tag);
    int k, m;
    logic ovf;
    logic [7:0] res;
    in = {1'b0, 1'b0, sl[1:0], 1'b1};
    k  = cyc;
    m  = $urandom_range(n - 1, 0);
    push(k + 2 + m, 8'(imin(m >> sl, 255)), {tag, "_live"});
    step(n);
    in  = {1'b0, 1'b1, sl[1:0], 1'b1};
    ovf = (((n - 1) >> sl) >= 256);
    res = ovf ? 8'd255 : 8'(imin(n >> sl, 255));
    push(cyc + 2, res, {tag, "_result"});
    step(3);
    in[4] = 1'b1;
    push(cyc + 1, status(ovf ? 3 : 2, sl), {tag, "_status"});
    step(2);
    in = 5'd0;
    step(2);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    step(5);
    reset = 1'b0;
    push(cyc, 8'h00, "reset_out");
    step(400);
    push(cyc, 8'h00, "idle_hold");
    in = 5'b10000;
    push(cyc + 1, 8'h00, "idle_status");
    step(2);
    in = 5'd0;
    step(2);

    measure(0, 10, "sel0_n10");
    measure(3, 80, "sel3_n80");
    measure(0, 300, "sel0_ovf");
    measure(1, 37, "rearm_ovf");

    // Start and stop together while running: stop wins.
    in = 5'b00001;
    k  = cyc;
    step(2);
    in = 5'd0;
    step(8);
    in = 5'b01001;
    push(cyc + 2, 8'd10, "both_run_result");
    step(3);
    in = 5'b11001;
    push(cyc + 1, 8'h80, "both_run_status");
    step(2);
    in = 5'd0;
    step(2);

    // Same pattern in DONE: start wins.
    in = 5'b11001;
    push(cyc + 2, 8'h41, "both_done_status");
    step(3);
    in = 5'd0;
    step(2);

    // Same pattern in IDLE: start wins.
    reset = 1'b1;
    step(1);
    push(cyc, 8'h00, "reset_idle");
    reset = 1'b0;
    in = 5'b11001;
    push(cyc + 1, 8'h00, "both_idle_pre");
    push(cyc + 2, 8'h41, "both_idle_status");
    step(3);
    in = 5'd0;
    step(2);

    // Restart while running, then reset at cnt=50.
    in = 5'b00001;
    k  = cyc;
    push(k + 52, 8'd50, "midrun_cnt");
    step(52);
    reset = 1'b1;
    in = 5'd0;
    push(cyc + 1, 8'h00, "midrun_reset");
    step(1);
    reset = 1'b0;
    in = 5'b10000;
    push(cyc + 1, 8'h00, "after_reset_status");
    step(2);
    in = 5'd0;
    step(2);

    for (int i = 0; i < 10; i++) begin
      measure($urandom_range(3, 0), $urandom_range(600, 1), "rand");
    end

    step(5);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
